mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_rr_arbiter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   state_e    - sequencer states (IDLE, XFER, DONE)
//   SIZE_*     - transaction size encoding
//   GNT_*      - port identifiers used for grant and last-grant tracking
//   WORD_BYTES - byte accesses per word transaction
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the two requester ports, the completion/status
// outputs and the byte-wide memory pins.
//   slave  - arbiter side: takes requests and MemData, drives acks, rdata,
//            busy and the memory strobes/address/write byte.
//   master - environment side (requesters plus memory), the mirror image.
interface mem_port_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic        a_size;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic        b_size;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic        a_ack;
    logic        b_ack;
    logic [31:0] rdata;
    logic        busy;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  Address;
    logic [7:0]  Write_data;
    logic [7:0]  MemData;

    modport slave (
        input  a_req, a_we, a_size, a_addr, a_wdata,
        input  b_req, b_we, b_size, b_addr, b_wdata,
        input  MemData,
        output a_ack, b_ack, rdata, busy,
        output MemRead, MemWrite, Address, Write_data
    );

    modport master (
        output a_req, a_we, a_size, a_addr, a_wdata,
        output b_req, b_we, b_size, b_addr, b_wdata,
        output MemData,
        input  a_ack, b_ack, rdata, busy,
        input  MemRead, MemWrite, Address, Write_data
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way round-robin arbiter.
//   ph1    - clock
//   reset  - asynchronous active-high reset (last grant returns to B)
//   req    - request vector, bit 0 = port A, bit 1 = port B
//   update - strobe: record the current grant as the last grant
//   gnt    - one-hot grant, all-zero when nothing requests
module mem_rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic       ph1,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Tie goes to whichever port was not served last.
            2'b11:   gnt = (last_q == GNT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            last_q <= GNT_B;
        end else if (update && (gnt != 2'b00)) begin
            last_q <= gnt[1] ? GNT_B : GNT_A;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants a single-port byte-wide memory to port A or B and
// sequences each byte or big-endian word transaction as byte accesses.
//   ph1   - clock, all state updates on its rising edge
//   reset - asynchronous active-high reset
//   bus   - requester ports, ack/rdata/busy and memory pins (slave modport)
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input logic              ph1,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    state_e      state_q, state_d;
    logic [1:0]  k_q;
    logic        gnt_q;
    logic        we_q;
    logic        size_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] sh_q;
    logic [31:0] rdata_q;

    logic [1:0]  req;
    logic [1:0]  gnt_oh;
    logic        grant_now;
    logic [1:0]  last_k;
    logic [31:0] sh_next;

    assign req       = {bus.b_req, bus.a_req};
    assign grant_now = (state_q == IDLE) && (req != 2'b00);
    assign last_k    = (size_q == SIZE_WORD) ? 2'(WORD_BYTES - 1) : 2'd0;
    assign sh_next   = {sh_q[23:0], bus.MemData};

    mem_rr_arbiter u_rr (
        .ph1    (ph1),
        .reset  (reset),
        .req    (req),
        .update (grant_now),
        .gnt    (gnt_oh)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req != 2'b00) state_d = XFER;
            XFER:    if (k_q == last_k) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            gnt_q   <= GNT_A;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            sh_q    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (grant_now) begin
                gnt_q   <= gnt_oh[0] ? GNT_A : GNT_B;
                we_q    <= gnt_oh[0] ? bus.a_we    : bus.b_we;
                size_q  <= gnt_oh[0] ? bus.a_size  : bus.b_size;
                addr_q  <= gnt_oh[0] ? bus.a_addr  : bus.b_addr;
                wdata_q <= gnt_oh[0] ? bus.a_wdata : bus.b_wdata;
                k_q     <= 2'd0;
                sh_q    <= 32'd0;
            end else if (state_q == XFER) begin
                k_q  <= k_q + 2'd1;
                sh_q <= sh_next;
                // Capture includes the byte arriving on this same edge.
                if ((k_q == last_k) && !we_q) begin
                    rdata_q <= sh_next;
                end
            end
        end
    end

    always_comb begin
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = 8'd0;
        bus.Write_data = 8'd0;
        if (state_q == XFER) begin
            bus.MemRead  = !we_q;
            bus.MemWrite = we_q;
            bus.Address  = addr_q + {6'd0, k_q};
            if (size_q == SIZE_WORD) begin
                // Big-endian: first access carries the most significant byte.
                unique case (k_q)
                    2'd0:    bus.Write_data = wdata_q[31:24];
                    2'd1:    bus.Write_data = wdata_q[23:16];
                    2'd2:    bus.Write_data = wdata_q[15:8];
                    default: bus.Write_data = wdata_q[7:0];
                endcase
            end else begin
                bus.Write_data = wdata_q[7:0];
            end
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.a_ack = (state_q == DONE) && (gnt_q == GNT_A);
    assign bus.b_ack = (state_q == DONE) && (gnt_q == GNT_B);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic ph1 = 1'b0;
    logic reset;
    always #5 ph1 = ~ph1;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    // Byte-wide memory: combinational read, write on the ph1 edge.
    logic [7:0] mem [256];
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;
    always @(posedge ph1) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.MemWrite) mem[bus.Address] <= bus.Write_data;
    end
    assign bus.MemData = mem[bus.Address];

    // Reference model state.
    logic [7:0]  ref_mem [256];
    bit          m_last;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic        size;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          port;
        logic        we;
        logic        size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic drive_port(input bit p, input bit rq, input txn_t t);
        if (p == 1'b0) begin
            bus.a_req = rq; bus.a_we = t.we; bus.a_size = t.size;
            bus.a_addr = t.addr; bus.a_wdata = t.wdata;
        end else begin
            bus.b_req = rq; bus.b_we = t.we; bus.b_size = t.size;
            bus.b_addr = t.addr; bus.b_wdata = t.wdata;
        end
    endtask

    task automatic do_reset();
        txn_t z;
        logic [31:0] prog;
        logic [7:0]  v;
        z = '{we: 1'b0, size: 1'b0, addr: 8'd0, wdata: 32'd0};
        prog = 32'h20030008;
        reset = 1'b1;
        drive_port(1'b0, 1'b0, z);
        drive_port(1'b1, 1'b0, z);
        #1;
        check("reset_outputs",
              {22'd0, bus.a_ack, bus.b_ack, bus.busy, bus.MemRead, bus.MemWrite,
               bus.Address != 8'd0, bus.Write_data != 8'd0, bus.rdata != 32'd0, 2'b00},
              32'd0);
        for (int i = 0; i < 256; i++) begin
            v = (i < 4) ? 8'(prog >> (8 * (3 - i))) : (8'(i) ^ 8'hA5);
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = v;
            ref_mem[i] = v;
            tick();
        end
        ld_en  = 1'b0;
        m_last = 1'b1;
        m_rdata = 32'd0;
        reset = 1'b0;
        tick();
    endtask

    // Runs requests on A and/or B until every requester has been served,
    // predicting grant order, latency, bus activity and rdata from the model.
    task automatic run_round(input bit ra, input bit rb, input txn_t ta, input txn_t tbx,
                             output logic [31:0] last_rd, output int last_lat);
        bit pa, pb, win, got;
        int elapsed, xk, nb;
        txn_t t;
        logic [31:0] exp_rd;
        last_rd = 32'd0; last_lat = 0;
        drive_port(1'b0, ra, ta);
        drive_port(1'b1, rb, tbx);
        pa = ra; pb = rb; elapsed = 0;
        while (pa || pb) begin
            win = (pa && pb) ? !m_last : !pa;
            t = win ? tbx : ta;
            nb = t.size ? 4 : 1;
            exp_rd = m_rdata;
            if (!t.we) begin
                exp_rd = 32'd0;
                for (int i = 0; i < nb; i++)
                    exp_rd = (exp_rd << 8) | {24'd0, ref_mem[8'(t.addr + 8'(i))]};
            end
            xk = 0; got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                elapsed++;
                if (bus.MemRead || bus.MemWrite) begin
                    check("xfer_addr", {24'd0, bus.Address}, {24'd0, 8'(t.addr + 8'(xk))});
                    check("xfer_strobes", {30'd0, bus.MemWrite, bus.MemRead},
                          t.we ? 32'd2 : 32'd1);
                    if (t.we && xk < nb)
                        check("xfer_wbyte", {24'd0, bus.Write_data},
                              {24'd0, 8'(t.wdata >> (8 * (nb - 1 - xk)))});
                    xk++;
                end
                if (bus.a_ack || bus.b_ack) got = 1'b1;
            end
            check("ack_seen", {31'd0, got}, 32'd1);
            check("ack_port", {30'd0, bus.b_ack, bus.a_ack}, win ? 32'd2 : 32'd1);
            check("latency", elapsed, nb + 1);
            check("rdata", bus.rdata, exp_rd);
            check("xfer_count", xk, nb);
            if (t.we)
                for (int i = 0; i < nb; i++)
                    ref_mem[8'(t.addr + 8'(i))] = 8'(t.wdata >> (8 * (nb - 1 - i)));
            m_rdata = exp_rd;
            m_last = win;
            drive_port(win, 1'b0, t);
            if (win) pb = 1'b0; else pa = 1'b0;
            last_rd = bus.rdata; last_lat = elapsed;
            elapsed = -1;
            if (!got) begin pa = 1'b0; pb = 1'b0; end
        end
        tick();
        check("idle_after_round", {31'd0, bus.busy}, 32'd0);
    endtask

    vec_t vecs [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t ta, tbx;
        logic [31:0] rd;
        int lat, cyc, n_ack, t_ack0, t_ack1, bad;
        bit order [4];
        logic [31:0] rds [4];
        logic [7:0] old18, old19;

        ld_en = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;

        // Directed table on the standard program image.
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd0,   32'h0,        32'h20030008, 5};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd255, 32'h15,       32'h20030008, 2};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'd254, 32'hDEADBEEF, 32'h20030008, 5};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd255, 32'h0,        32'h000000AD, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd254, 32'h0,        32'hDEADBEEF, 5};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'd0,   32'h0,        32'hBEEF0008, 5};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd3,   32'h0,        32'h00000008, 2};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            ta = '{we: vecs[i].we, size: vecs[i].size, addr: vecs[i].addr,
                   wdata: vecs[i].wdata};
            run_round(!vecs[i].port, vecs[i].port, ta, ta, rd, lat);
            check("vec_rdata", rd, vecs[i].exp_rdata);
            check("vec_latency", lat, vecs[i].exp_lat);
            if (i == 1) check("mem255_byte_write", {24'd0, mem[255]}, 32'h15);
        end
        check("wrap_mem254", {24'd0, mem[254]}, 32'hDE);
        check("wrap_mem255", {24'd0, mem[255]}, 32'hAD);
        check("wrap_mem0",   {24'd0, mem[0]},   32'hBE);
        check("wrap_mem1",   {24'd0, mem[1]},   32'hEF);

        // Both ports held together from reset: A, B, A, B.
        do_reset();
        ta  = '{we: 1'b1, size: 1'b0, addr: 8'd100, wdata: 32'h5A};
        tbx = '{we: 1'b0, size: 1'b0, addr: 8'd100, wdata: 32'h0};
        drive_port(1'b0, 1'b1, ta);
        drive_port(1'b1, 1'b1, tbx);
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            tick();
            if (bus.a_ack || bus.b_ack) begin
                check("arb_ack_onehot", {31'd0, bus.a_ack && bus.b_ack}, 32'd0);
                order[n_ack] = bus.b_ack;
                rds[n_ack] = bus.rdata;
                n_ack++;
                if (n_ack == 4) begin
                    drive_port(1'b0, 1'b0, ta);
                    drive_port(1'b1, 1'b0, tbx);
                end
            end
        end
        check("arb_ack_count", n_ack, 4);
        if (n_ack == 4) begin
            check("arb_order", {28'd0, order[0], order[1], order[2], order[3]}, 32'b0101);
            check("arb_rdata0_write", rds[0], 32'h0);
            check("arb_rdata1_read",  rds[1], 32'h5A);
            check("arb_rdata2_write", rds[2], 32'h5A);
            check("arb_rdata3_read",  rds[3], 32'h5A);
        end
        tick();

        // Reset during the third byte of a word write at 16.
        do_reset();
        old18 = mem[18]; old19 = mem[19];
        ta = '{we: 1'b1, size: 1'b1, addr: 8'd16, wdata: 32'h11223344};
        drive_port(1'b0, 1'b1, ta);
        tick(); tick(); tick();
        check("midreset_at_k2", {24'd0, bus.Address}, 32'd18);
        reset = 1'b1;
        #1;
        check("midreset_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        drive_port(1'b0, 1'b0, ta);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.a_ack || bus.b_ack || bus.busy) bad++;
        end
        check("midreset_no_ack", bad, 0);
        check("midreset_mem16", {24'd0, mem[16]}, 32'h11);
        check("midreset_mem17", {24'd0, mem[17]}, 32'h22);
        check("midreset_mem18", {24'd0, mem[18]}, {24'd0, old18});
        check("midreset_mem19", {24'd0, mem[19]}, {24'd0, old19});

        // Back-to-back byte reads at 3 with a_req held across the ack.
        do_reset();
        ta = '{we: 1'b0, size: 1'b0, addr: 8'd3, wdata: 32'h0};
        drive_port(1'b0, 1'b1, ta);
        n_ack = 0; t_ack0 = 0; t_ack1 = 0;
        for (int c = 0; c < 20 && n_ack < 2; c++) begin
            tick();
            if (bus.a_ack) begin
                check("b2b_rdata", bus.rdata, 32'h00000008);
                if (n_ack == 0) t_ack0 = c; else t_ack1 = c;
                n_ack++;
                if (n_ack == 2) drive_port(1'b0, 1'b0, ta);
            end
        end
        check("b2b_ack_count", n_ack, 2);
        check("b2b_spacing", t_ack1 - t_ack0, 3);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            ta  = '{we: 1'($urandom_range(0, 1)), size: 1'($urandom_range(0, 1)),
                    addr: 8'($urandom), wdata: $urandom};
            tbx = '{we: 1'($urandom_range(0, 1)), size: 1'($urandom_range(0, 1)),
                    addr: 8'($urandom), wdata: $urandom};
            run_round(mode != 1, mode != 0, ta, tbx, rd, lat);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("random_mem_image", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
